// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and types for the memory-port arbiter and its tag owner table.
package mem_arbiter_pkg;

  localparam int MEM_TAG_W        = 4;
  localparam int MEM_STARVE_LIMIT = 4;
  localparam int MEM_ADDR_W       = 64;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_tag_table.sv
// Owner table for outstanding load tags: one valid/owner pair per tag, a set port,
// a lookup port that clears on hit (set wins on the same tag), and a registered count.
module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int TAG_W = MEM_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en_i,
  input  logic [TAG_W-1:0] set_tag_i,
  input  req_id_e          set_owner_i,
  input  logic [TAG_W-1:0] lkp_tag_i,
  output logic             lkp_hit_o,
  output req_id_e          lkp_owner_o,
  output logic [TAG_W:0]   count_o
);

  localparam int N = 1 << TAG_W;

  logic [N-1:0]   valid_q, valid_d;
  logic [N-1:0]   owner_q, owner_d;
  logic [TAG_W:0] count_q, count_d;

  always_comb begin
    lkp_hit_o   = (lkp_tag_i != '0) && valid_q[lkp_tag_i];
    lkp_owner_o = req_id_e'(owner_q[lkp_tag_i]);
    valid_d     = valid_q;
    owner_d     = owner_q;
    if (lkp_hit_o) valid_d[lkp_tag_i] = 1'b0;
    // Applied after the clear so a tag returned and reissued in one cycle stays owned.
    if (set_en_i && (set_tag_i != '0)) begin
      valid_d[set_tag_i] = 1'b1;
      owner_d[set_tag_i] = set_owner_i;
    end
    count_d = '0;
    for (int i = 0; i < N; i++) count_d = count_d + {{TAG_W{1'b0}}, valid_d[i]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      owner_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one tagged memory port between fetch and data requesters, data first,
// with a starvation bound on fetch; routes returning load data to the tag owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TAG_W        = MEM_TAG_W,
  parameter int STARVE_LIMIT = MEM_STARVE_LIMIT,
  parameter int ADDR_W       = MEM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              icache_req_valid,
  input  logic [ADDR_W-1:0] icache_req_addr,
  output logic              icache_req_ack,
  output logic [TAG_W-1:0]  icache_req_tag,
  output logic              icache_rsp_valid,
  output logic [TAG_W-1:0]  icache_rsp_tag,
  output logic [63:0]       icache_rsp_data,
  input  logic              dcache_req_valid,
  input  logic [1:0]        dcache_req_cmd,
  input  logic [ADDR_W-1:0] dcache_req_addr,
  input  logic [63:0]       dcache_req_data,
  output logic              dcache_req_ack,
  output logic [TAG_W-1:0]  dcache_req_tag,
  output logic              dcache_rsp_valid,
  output logic [TAG_W-1:0]  dcache_rsp_tag,
  output logic [63:0]       dcache_rsp_data,
  output logic [1:0]        proc2mem_command,
  output logic [ADDR_W-1:0] proc2mem_addr,
  output logic [63:0]       proc2mem_data,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  output logic [TAG_W:0]    mem_outstanding,
  output logic              arb_err,
  output arb_state_e        arb_state
);

  // Handshake: a request is offered while *_req_valid is high and is taken only in a
  // cycle where *_req_ack is high; the requester must hold its fields until then.

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e  state_q;
  logic [SW-1:0] starve_q, starve_d;
  logic        err_q;
  logic        sel_valid, accept, rsp_hit;
  req_id_e     sel_id, rsp_owner;
  logic [1:0]  sel_cmd;

  always_comb begin
    sel_valid = 1'b0;
    sel_id    = REQ_I;
    // All combinational outputs are quiet while reset is held.
    if (reset) begin
      if (state_q == ARB_HOLD_I && icache_req_valid) begin
        sel_valid = 1'b1; sel_id = REQ_I;
      end else if (state_q == ARB_HOLD_D && dcache_req_valid) begin
        sel_valid = 1'b1; sel_id = REQ_D;
      end else if (starve_q == STARVE_MAX && icache_req_valid) begin
        sel_valid = 1'b1; sel_id = REQ_I;
      end else if (dcache_req_valid) begin
        sel_valid = 1'b1; sel_id = REQ_D;
      end else if (icache_req_valid) begin
        sel_valid = 1'b1; sel_id = REQ_I;
      end
    end
    sel_cmd          = !sel_valid ? MEM_NONE : ((sel_id == REQ_I) ? MEM_LOAD : dcache_req_cmd);
    accept           = sel_valid && (mem2proc_response != '0);
    proc2mem_command = sel_cmd;
    proc2mem_addr    = !sel_valid ? '0 : ((sel_id == REQ_I) ? icache_req_addr : dcache_req_addr);
    proc2mem_data    = (sel_cmd == MEM_STORE) ? dcache_req_data : '0;
    icache_req_ack   = accept && (sel_id == REQ_I);
    dcache_req_ack   = accept && (sel_id == REQ_D);
    icache_req_tag   = icache_req_ack ? mem2proc_response : '0;
    dcache_req_tag   = dcache_req_ack ? mem2proc_response : '0;

    icache_rsp_valid = reset && rsp_hit && (rsp_owner == REQ_I);
    dcache_rsp_valid = reset && rsp_hit && (rsp_owner == REQ_D);
    icache_rsp_tag   = icache_rsp_valid ? mem2proc_tag  : '0;
    icache_rsp_data  = icache_rsp_valid ? mem2proc_data : '0;
    dcache_rsp_tag   = dcache_rsp_valid ? mem2proc_tag  : '0;
    dcache_rsp_data  = dcache_rsp_valid ? mem2proc_data : '0;

    if (icache_req_valid && !icache_req_ack)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
    else
      starve_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      // A refused request parks the arbiter on its requester until memory takes it.
      if (!sel_valid || accept) state_q <= ARB_IDLE;
      else state_q <= (sel_id == REQ_I) ? ARB_HOLD_I : ARB_HOLD_D;
      starve_q <= starve_d;
      if ((mem2proc_tag != '0) && !rsp_hit) err_q <= 1'b1;
    end
  end

  mem_tag_table #(.TAG_W(TAG_W)) u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .set_en_i    (accept && (sel_cmd == MEM_LOAD)),
    .set_tag_i   (mem2proc_response),
    .set_owner_i (sel_id),
    .lkp_tag_i   (mem2proc_tag),
    .lkp_hit_o   (rsp_hit),
    .lkp_owner_o (rsp_owner),
    .count_o     (mem_outstanding)
  );

  assign arb_err   = err_q;
  assign arb_state = state_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single tagged memory port between the instruction-fetch requester (Icache fill path feeding the 2-wide fetch stage) and the data requester (Dcache load/store path). Each cycle it picks one requester, drives the memory command, and acks the winner with the accepted tag. It records which requester owns each outstanding load tag and routes returning data to that requester. Data side has priority; a starvation counter bounds fetch stalls.

Parameters:
TAG_W, 4, memory tag width; tag 0 means "no tag", so 2^TAG_W-1 usable tags
STARVE_LIMIT, 4, consecutive refused fetch-request cycles before fetch gets priority
ADDR_W, 64, address width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-low
icache_req_valid  in  1  fetch load request pending
icache_req_addr  in  ADDR_W  fetch load address
icache_req_ack  out  1  fetch request accepted by memory this cycle
icache_req_tag  out  TAG_W  tag assigned to the accepted fetch request
icache_rsp_valid  out  1  load data for fetch returned this cycle
icache_rsp_tag  out  TAG_W  tag of returned fetch data
icache_rsp_data  out  64  returned fetch data
dcache_req_valid  in  1  data request pending
dcache_req_cmd  in  2  LOAD=1, STORE=2
dcache_req_addr  in  ADDR_W  data address
dcache_req_data  in  64  store data
dcache_req_ack / dcache_req_tag / dcache_rsp_valid / dcache_rsp_tag / dcache_rsp_data  out  1/TAG_W/1/TAG_W/64  same as fetch side
proc2mem_command  out  2  NONE=0, LOAD=1, STORE=2
proc2mem_addr  out  ADDR_W  memory address
proc2mem_data  out  64  store data
mem2proc_response  in  TAG_W  nonzero = request accepted with this tag
mem2proc_data  in  64  returned data
mem2proc_tag  in  TAG_W  nonzero = data for this tag valid
mem_outstanding  out  TAG_W+1  number of owned outstanding load tags
arb_err  out  1  sticky: response arrived for an unowned tag

Behaviour:
- Reset (reset=0, async): state IDLE, owner table all invalid, starve counter 0, arb_err 0. Every output is 0, including proc2mem_command=NONE.
- States: IDLE, HOLD_I, HOLD_D.
- In IDLE, selection is: fetch if starve counter==STARVE_LIMIT and icache_req_valid; else data if dcache_req_valid; else fetch if icache_req_valid; else none (command NONE).
- In HOLD_x, the selection is forced to requester x while its valid is high.
- Selected request drives proc2mem_* combinationally. Fetch requests are always LOAD. proc2mem_data is 0 unless the command is STORE.
- Accept: mem2proc_response!=0 while a command is driven. The winner's req_ack=1 and req_tag=mem2proc_response in the same cycle (Mealy). Next state is IDLE.
- Refused (response==0): next state is HOLD of the selected requester, so its address stays on the bus until accepted. If the held requester drops valid, return to IDLE and select normally that cycle.
- An accepted LOAD sets owner[tag] to {valid, requester} at the posedge. A STORE creates no entry.
- Return: if mem2proc_tag!=0 and owner[tag] is valid, assert that owner's rsp_valid with rsp_tag=mem2proc_tag and rsp_data=mem2proc_data combinationally, then clear the entry.
- If mem2proc_tag is unowned, drop the data and set arb_err (held until reset).
- If the same tag is returned and reissued in one cycle, routing uses the old owner; the new set wins over the clear.
- Starve counter: increments, saturating at STARVE_LIMIT, on every cycle with icache_req_valid && !icache_req_ack. Clears on icache_req_ack or !icache_req_valid.
- mem_outstanding is registered and equals the popcount of valid owner entries.
- Reset mid-HOLD or with loads outstanding returns to IDLE with an empty table. Later returns of those tags set arb_err.

Decomposition:
- Shared package: MEM_NONE/LOAD/STORE encodings, TAG_W, requester id enum (REQ_I, REQ_D), arbiter state enum.
- One sub-module, mem_tag_table: 2^TAG_W-entry owner table with set port, clear/lookup port, same-cycle set-over-clear priority, and registered valid count.

Test Plan:
1. Hold reset=0 with all inputs active -> every output is 0 and mem_outstanding=0. Release -> IDLE with no command until a requester is valid.
2. Both valid: D load 0x100, I load 0x200, response=3 -> proc2mem_addr=0x100, dcache_req_ack=1, tag 3. Next cycle response=4 -> icache_req_ack=1, tag 4, mem_outstanding=2.
3. STARVE_LIMIT=4, D continuously valid with every request accepted, I valid -> I refused 4 cycles, granted in cycle 5 over D, counter back to 0.
4. I alone at 0x40, response=0 for 2 cycles; D raises valid in the 2nd cycle -> proc2mem_addr stays 0x40 (HOLD_I) until response=7 -> icache_req_ack=1, tag 7.
5. I load tag 5, D load tag 6 outstanding; mem2proc_tag=6, data=0xDEAD -> dcache_rsp_valid=1 with data 0xDEAD, icache_rsp_valid=0, mem_outstanding 2->1. Then mem2proc_tag=9 -> no rsp_valid, arb_err=1 and stays high.
6. D store accepted with tag 2 -> mem_outstanding unchanged, and a later tag-2 return sets arb_err. Assert reset=0 during HOLD_D -> outputs 0 immediately, and after release state is IDLE with an empty table.
